// File: rtl/rpn_pkg.sv
// Shared opcode, error-code and FSM-state types for the RPN stack controller.
package rpn_pkg;

    localparam int unsigned BASE_TEN = 10;

    typedef enum logic [2:0] {
        OpDigit = 3'd0,
        OpEnter = 3'd1,
        OpAdd   = 3'd2,
        OpSub   = 3'd3,
        OpMul   = 3'd4,
        OpDiv   = 3'd5,
        OpDrop  = 3'd6,
        OpClear = 3'd7
    } rpn_op_e;

    typedef enum logic [2:0] {
        ErrNone      = 3'd0,
        ErrUnderflow = 3'd1,
        ErrOverflow  = 3'd2,
        ErrDivZero   = 3'd3,
        ErrBadDigit  = 3'd4,
        ErrNoDiv     = 3'd5
    } rpn_err_e;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StDiv   = 3'd1,
        StPop   = 3'd2,
        StWrite = 3'd3,
        StClear = 3'd4
    } rpn_state_e;

endpackage

// File: rtl/rpn_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, WIDTH iterations after start.
// done is high during the final iteration; quotient is valid from the following cycle.
module rpn_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dsr_q};
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        if (start) begin
            rem_d = '0;
            quo_d = dividend;
            dsr_d = divisor;
            cnt_d = CntW'(WIDTH);
        end else if (cnt_q != '0) begin
            // A negative trial difference means restore the shifted remainder.
            rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dsr_q <= dsr_d;
            cnt_q <= cnt_d;
        end
    end

    assign done     = (cnt_q == CntW'(1));
    assign quotient = quo_q;

endmodule

// File: rtl/rpn_stack_controller.sv
// RPN keypad command sequencer: each accepted command becomes single-cycle registered stack strobes.
// Hardware DIV is built only when RPN_DIVIDER_EN is defined; otherwise DIV reports NO_DIV.
module rpn_stack_controller #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_COUNT = 63
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [3:0]       cmd_digit,
    output logic             stk_push,
    output logic             stk_pop,
    output logic             stk_write,
    output logic [WIDTH-1:0] stk_value,
    input  logic [WIDTH-1:0] stk_top,
    input  logic [WIDTH-1:0] stk_next,
    input  logic [5:0]       stk_count,
    input  logic             stk_error,
    output logic             busy,
    output logic [2:0]       err_code
);

    import rpn_pkg::*;

    rpn_state_e       state_q, state_d;
    rpn_op_e          op, op_q;
    rpn_err_e         err_q, err_d, new_err;
    logic [WIDTH-1:0] opa_q, opb_q;
    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] result;
    logic             push_q, push_d;
    logic             pop_q, pop_d;
    logic             write_q, write_d;
    logic             accept;
    logic             have_two;
    logic             full;
    logic             top_zero;
    logic             clr_more;

    assign op        = rpn_op_e'(cmd_op);
    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign accept    = cmd_valid & cmd_ready;
    assign have_two  = (stk_count >= 6'd2);
    assign full      = (32'(stk_count) >= MAX_COUNT);
    assign top_zero  = (stk_top == '0);
    // stk_count lags a pop in flight by one cycle, so discount it while draining.
    assign clr_more  = (stk_count > (pop_q ? 6'd2 : 6'd1));

`ifdef RPN_DIVIDER_EN
    logic             div_start;
    logic             div_done;
    logic [WIDTH-1:0] div_quotient;

    assign div_start = accept && (op == OpDiv) && have_two && !top_zero;

    rpn_divider #(
        .WIDTH(WIDTH)
    ) u_divider (
        .clock   (clock),
        .reset   (reset),
        .start   (div_start),
        .dividend(stk_next),
        .divisor (stk_top),
        .done    (div_done),
        .quotient(div_quotient)
    );
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StClear;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (op)
                        OpAdd, OpSub, OpMul: begin
                            if (have_two) state_d = StPop;
                        end
`ifdef RPN_DIVIDER_EN
                        OpDiv: begin
                            if (have_two && !top_zero) state_d = StDiv;
                        end
`endif
                        OpClear: state_d = StClear;
                        default: state_d = StIdle;
                    endcase
                end
            end
`ifdef RPN_DIVIDER_EN
            StDiv:   if (div_done) state_d = StPop;
`else
            StDiv:   state_d = StIdle;
`endif
            StPop:   state_d = StWrite;
            StWrite: state_d = StIdle;
            StClear: if (!clr_more) state_d = StIdle;
            default: state_d = StClear;
        endcase
    end

    always_comb begin
        result = '0;
        unique case (op_q)
            OpAdd:   result = opa_q + opb_q;
            OpSub:   result = opa_q - opb_q;
            OpMul:   result = opa_q * opb_q;
`ifdef RPN_DIVIDER_EN
            OpDiv:   result = div_quotient;
`endif
            default: result = '0;
        endcase
    end

    // Output logic: strobes are decided here and registered, so each lands with its state.
    always_comb begin
        push_d  = 1'b0;
        pop_d   = 1'b0;
        write_d = 1'b0;
        value_d = value_q;
        new_err = ErrNone;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (op)
                        OpDigit: begin
                            if (cmd_digit > 4'd9) begin
                                new_err = ErrBadDigit;
                            end else begin
                                write_d = 1'b1;
                                value_d = stk_top * WIDTH'(BASE_TEN) + WIDTH'(cmd_digit);
                            end
                        end
                        OpEnter: begin
                            if (full) new_err = ErrOverflow;
                            else      push_d  = 1'b1;
                        end
                        OpAdd, OpSub, OpMul: begin
                            if (!have_two) new_err = ErrUnderflow;
                            else           pop_d   = 1'b1;
                        end
                        OpDiv: begin
`ifdef RPN_DIVIDER_EN
                            if (!have_two)    new_err = ErrUnderflow;
                            else if (top_zero) new_err = ErrDivZero;
`else
                            new_err = ErrNoDiv;
`endif
                        end
                        OpDrop: begin
                            if (stk_count == 6'd1) begin
                                write_d = 1'b1;
                                value_d = '0;
                            end else begin
                                pop_d = 1'b1;
                            end
                        end
                        OpClear: ;
                        default: ;
                    endcase
                end
            end
`ifdef RPN_DIVIDER_EN
            StDiv:   if (div_done) pop_d = 1'b1;
`else
            StDiv:   ;
`endif
            StPop: begin
                write_d = 1'b1;
                value_d = result;
            end
            StWrite: ;
            StClear: begin
                if (clr_more) begin
                    pop_d = 1'b1;
                end else begin
                    write_d = 1'b1;
                    value_d = '0;
                end
            end
            default: ;
        endcase

        // First error sticks until CLEAR; stack overflow is reported from any state.
        err_d = err_q;
        if (accept && (op == OpClear)) begin
            err_d = ErrNone;
        end else if (err_q == ErrNone) begin
            if (new_err != ErrNone) err_d = new_err;
            else if (stk_error)     err_d = ErrOverflow;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            push_q  <= 1'b0;
            pop_q   <= 1'b0;
            write_q <= 1'b0;
            value_q <= '0;
            err_q   <= ErrNone;
            op_q    <= OpDigit;
            opa_q   <= '0;
            opb_q   <= '0;
        end else begin
            push_q  <= push_d;
            pop_q   <= pop_d;
            write_q <= write_d;
            value_q <= value_d;
            err_q   <= err_d;
            if (accept) begin
                op_q  <= op;
                opa_q <= stk_next;
                opb_q <= stk_top;
            end
        end
    end

    assign stk_push  = push_q;
    assign stk_pop   = pop_q;
    assign stk_write = write_q;
    assign stk_value = value_q;
    assign err_code  = err_q;

endmodule

// File: tb/tb_rpn_stack_controller.sv
// Directed bench for rpn_stack_controller with a behavioural 64-entry stack model.
// Define RPN_DIVIDER_EN to exercise the hardware divide path.
module tb_rpn_stack_controller;

    localparam logic [2:0] OP_DIGIT = 3'd0;
    localparam logic [2:0] OP_ENTER = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_MUL   = 3'd4;
    localparam logic [2:0] OP_DIV   = 3'd5;
    localparam logic [2:0] OP_DROP  = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_digit;
    logic        stk_push;
    logic        stk_pop;
    logic        stk_write;
    logic [31:0] stk_value;
    logic [31:0] stk_top;
    logic [31:0] stk_next;
    logic [5:0]  stk_count;
    logic        stk_error;
    logic        busy;
    logic [2:0]  err_code;

    logic        preload;
    logic [31:0] mem [64];
    int          cnt     = 1;
    int          n_push  = 0;
    int          n_pop   = 0;
    int          n_write = 0;
    int          n_multi = 0;
    int          tests   = 0;
    int          fails   = 0;

    always #5 clock = ~clock;

    rpn_stack_controller #(
        .WIDTH    (32),
        .MAX_COUNT(63)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_digit(cmd_digit),
        .stk_push (stk_push),
        .stk_pop  (stk_pop),
        .stk_write(stk_write),
        .stk_value(stk_value),
        .stk_top  (stk_top),
        .stk_next (stk_next),
        .stk_count(stk_count),
        .stk_error(stk_error),
        .busy     (busy),
        .err_code (err_code)
    );

    // Stack model: no reset of its own, preloaded with 5 entries before the DUT leaves reset.
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= (i < 5) ? 32'(11 * (i + 1)) : 32'd0;
            cnt <= 5;
        end else begin
            if (int'(stk_push) + int'(stk_pop) + int'(stk_write) > 1) n_multi <= n_multi + 1;
            if (stk_push) begin
                mem[cnt] <= 32'd0;
                cnt      <= cnt + 1;
                n_push   <= n_push + 1;
            end else if (stk_pop) begin
                if (cnt > 1) cnt <= cnt - 1;
                n_pop <= n_pop + 1;
            end else if (stk_write) begin
                mem[cnt-1] <= stk_value;
                n_write    <= n_write + 1;
            end
        end
    end

    assign stk_count = 6'(cnt);
    assign stk_top   = mem[cnt-1];
    assign stk_next  = (cnt >= 2) ? mem[cnt-2] : 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait for ready, then one more cycle so a trailing strobe reaches the stack model.
    task automatic settle();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (cmd_ready !== 1'b1) check("settle_timeout", 32'(cmd_ready), 32'd1);
        @(negedge clock);
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] dig);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (cmd_ready !== 1'b1) check("send_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_digit = dig;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic measure(output int lat);
        lat = 0;
        while (cmd_ready !== 1'b1 && lat < 100) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic cmd(input logic [2:0] op);
        send(op, 4'd0);
        settle();
    endtask

    task automatic key_number(input int unsigned v);
        int unsigned d[10];
        int n = 0;
        do begin
            d[n] = v % 10;
            v    = v / 10;
            n++;
        end while (v != 0);
        for (int i = n - 1; i >= 0; i--) begin
            send(OP_DIGIT, 4'(d[i]));
            settle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int p0, w0, u0;
        reset     = 1'b1;
        preload   = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_digit = 4'd0;
        stk_error = 1'b0;

        // 1: reset drains a 5-entry stack
        repeat (2) @(negedge clock);
        preload = 1'b0;
        @(negedge clock);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_strobes", 32'({stk_push, stk_pop, stk_write}), 32'd0);
        check("rst_value", stk_value, 32'd0);
        p0 = n_pop;
        w0 = n_write;
        reset = 1'b0;
        settle();
        check("rst_pops", 32'(n_pop - p0), 32'd4);
        check("rst_writes", 32'(n_write - w0), 32'd1);
        check("rst_count", 32'(stk_count), 32'd1);
        check("rst_top", stk_top, 32'd0);
        check("rst_ready_after", 32'(cmd_ready), 32'd1);
        check("rst_err", 32'(err_code), 32'd0);

        // stack overflow flag sets OVERFLOW
        stk_error = 1'b1;
        @(negedge clock);
        stk_error = 1'b0;
        check("stkerr_err", 32'(err_code), 32'd2);
        cmd(OP_CLEAR);
        check("stkerr_cleared", 32'(err_code), 32'd0);

        // 2: 123 ENTER 4 ADD
        key_number(123);
        check("digits_top", stk_top, 32'd123);
        cmd(OP_ENTER);
        check("enter_count", 32'(stk_count), 32'd2);
        check("enter_top", stk_top, 32'd0);
        key_number(4);
        send(OP_ADD, 4'd0);
        measure(lat);
        check("add_latency", 32'(lat), 32'd2);
        settle();
        check("add_top", stk_top, 32'd127);
        check("add_count", 32'(stk_count), 32'd1);
        cmd(OP_DROP);
        check("drop_lone_top", stk_top, 32'd0);

        // 3: SUB, MUL
        key_number(3);
        cmd(OP_ENTER);
        key_number(5);
        cmd(OP_SUB);
        check("sub_top", stk_top, 32'hFFFF_FFFE);
        cmd(OP_CLEAR);
        key_number(65536);
        cmd(OP_ENTER);
        key_number(65536);
        cmd(OP_MUL);
        check("mul_wrap_top", stk_top, 32'd0);
        check("mul_wrap_count", 32'(stk_count), 32'd1);
        key_number(7);
        cmd(OP_ENTER);
        key_number(6);
        cmd(OP_MUL);
        check("mul_top", stk_top, 32'd42);
        key_number(9);
        cmd(OP_ENTER);
        cmd(OP_DROP);
        check("drop_pop_count", 32'(stk_count), 32'd1);
        check("drop_pop_top", stk_top, 32'd429);
        cmd(OP_CLEAR);

        // 4: DIV
        key_number(100);
        cmd(OP_ENTER);
        key_number(7);
        p0 = n_pop;
        w0 = n_write;
        send(OP_DIV, 4'd0);
        measure(lat);
        settle();
`ifdef RPN_DIVIDER_EN
        check("div_latency", 32'(lat), 32'd34);
        check("div_top", stk_top, 32'd14);
        check("div_count", 32'(stk_count), 32'd1);
        check("div_err", 32'(err_code), 32'd0);
        cmd(OP_CLEAR);
        key_number(5);
        cmd(OP_ENTER);
        cmd(OP_DIV);
        check("divzero_err", 32'(err_code), 32'd3);
        check("divzero_count", 32'(stk_count), 32'd2);
`else
        check("nodiv_latency", 32'(lat), 32'd0);
        check("nodiv_err", 32'(err_code), 32'd5);
        check("nodiv_count", 32'(stk_count), 32'd2);
        check("nodiv_strobes", 32'((n_pop - p0) + (n_write - w0)), 32'd0);
`endif
        cmd(OP_CLEAR);

        // 5: underflow, overflow at MAX_COUNT, sticky error, CLEAR
        check("clear_err", 32'(err_code), 32'd0);
        p0 = n_pop;
        w0 = n_write;
        cmd(OP_ADD);
        check("underflow_err", 32'(err_code), 32'd1);
        check("underflow_strobes", 32'((n_pop - p0) + (n_write - w0)), 32'd0);
        u0 = n_push;
        for (int i = 0; i < 63; i++) cmd(OP_ENTER);
        check("full_pushes", 32'(n_push - u0), 32'd62);
        check("full_count", 32'(stk_count), 32'd63);
        check("sticky_err", 32'(err_code), 32'd1);
        p0 = n_pop;
        cmd(OP_CLEAR);
        check("clear_pops", 32'(n_pop - p0), 32'd62);
        check("clear_count", 32'(stk_count), 32'd1);
        check("clear_err2", 32'(err_code), 32'd0);

        // 6: bad digit, reset mid-sequence
        key_number(8);
        w0 = n_write;
        send(OP_DIGIT, 4'd12);
        settle();
        check("baddigit_err", 32'(err_code), 32'd4);
        check("baddigit_writes", 32'(n_write - w0), 32'd0);
        check("baddigit_top", stk_top, 32'd8);
        cmd(OP_CLEAR);
        key_number(100);
        cmd(OP_ENTER);
        key_number(7);
        p0 = n_pop;
        w0 = n_write;
`ifdef RPN_DIVIDER_EN
        send(OP_DIV, 4'd0);
        repeat (5) @(negedge clock);
`else
        send(OP_ADD, 4'd0);
`endif
        reset = 1'b1;
        @(negedge clock);
        check("midrst_strobes", 32'({stk_push, stk_pop, stk_write}), 32'd0);
        check("midrst_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        settle();
        check("midrst_pops", 32'(n_pop - p0), 32'd1);
        check("midrst_writes", 32'(n_write - w0), 32'd1);
        check("midrst_top", stk_top, 32'd0);
        check("midrst_count", 32'(stk_count), 32'd1);

        check("one_strobe_per_cycle", 32'(n_multi), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
